// File: rtl/riscv_pushpop_lsu_seq_pkg.sv
// Shared types for the push/pop load-store sequencer.
//   pushpop_rsp_t   : bookkeeping entry kept per granted bus beat
//   pushpop_req_t   : contents of the single request stage
//   pushpop_state_e : sequencer FSM states
//   pushpop_addr()  : word-aligned SP-relative address
package riscv_pushpop_lsu_seq_pkg;

    localparam int PUSHPOP_MAX_OUTST_DEF = 2;

    typedef struct packed {
        logic       we;
        logic [4:0] rf_reg;
        logic       last;
    } pushpop_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [4:0]  rf_reg;
        logic        last;
    } pushpop_req_t;

    typedef enum logic [1:0] {
        PP_IDLE,
        PP_ISSUE,
        PP_DRAIN
    } pushpop_state_e;

    // sp + offset (mod 2^32) with the byte lane bits dropped
    function automatic logic [31:0] pushpop_addr(input logic [31:0] sp, input logic [31:0] off);
        logic [31:0] sum;
        sum = sp + off;
        return {sum[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/riscv_pushpop_rsp_fifo.sv
// Response bookkeeping FIFO: one pushpop_rsp_t per granted beat, popped when
// the matching response returns.
//   push_i/push_data_i : enqueue (ignored when full)
//   pop_i/pop_data_o   : dequeue / head entry (pop ignored when empty)
//   full_o/empty_o     : occupancy flags
module riscv_pushpop_rsp_fifo
    import riscv_pushpop_lsu_seq_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  pushpop_rsp_t push_data_i,
    input  logic         pop_i,
    output pushpop_rsp_t pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    pushpop_rsp_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OCC_W-1:0]         occ_q, occ_d;
    logic                     do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o     = (occ_q == OCC_W'(DEPTH));
    assign empty_o    = (occ_q == '0);
    assign do_push    = push_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign pop_data_o = mem_q[rptr_q];

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
        if (do_push) begin
            mem_d[wptr_q] = push_data_i;
            wptr_d        = ptr_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/riscv_pushpop_lsu_seq.sv
// Push/pop load-store sequencer. Turns per-register micro-ops from the push/pop
// controller into word transactions on the OBI data port, writes popped words
// back to the register file and reports sequence completion (plus any bus
// error) to the ID stage.
//   uop_*      : micro-op handshake and payload, sp_i sampled on accept
//   data_*     : OBI master (req/gnt address phase, rvalid response phase)
//   rf_*       : register-file write port for popped data
//   busy_o     : sequence in flight
//   done_o     : one-cycle completion pulse, err_o qualifies it
module riscv_pushpop_lsu_seq
    import riscv_pushpop_lsu_seq_pkg::*;
#(
    parameter int MAX_OUTSTANDING = PUSHPOP_MAX_OUTST_DEF,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uop_valid_i,
    output logic        uop_ready_o,
    input  logic        uop_push_i,
    input  logic [4:0]  uop_reg_i,
    input  logic [31:0] uop_offset_i,
    input  logic [31:0] uop_wdata_i,
    input  logic        uop_last_i,
    input  logic [31:0] sp_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [CNT_W:0] MAX_C = (CNT_W + 1)'(MAX_OUTSTANDING);

    pushpop_req_t   stage_q, stage_d;
    logic           stage_vld_q, stage_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           sticky_err_q, sticky_err_d;
    pushpop_state_e state_q, state_d;

    logic           uop_fire, gnt_fire, rsp_fire, seq_done;
    logic [CNT_W:0] in_flight;
    pushpop_rsp_t   fifo_in, fifo_head;
    logic           fifo_full, fifo_empty;

    // Granted-but-unanswered beats plus the one waiting in the stage. Keeping
    // this below the limit before accepting means a grant can never find the
    // response FIFO full.
    assign in_flight = {1'b0, cnt_q} + {{CNT_W{1'b0}}, stage_vld_q};
    assign gnt_fire  = stage_vld_q & data_gnt_i;
    assign rsp_fire  = data_rvalid_i & ~fifo_empty;

    // The FIFO-full term is implied by the count check; it only guards against
    // the two bookkeeping structures ever disagreeing.
    assign uop_ready_o = (~stage_vld_q | gnt_fire) & (in_flight < MAX_C) &
                         (state_q != PP_DRAIN) & ~fifo_full;
    assign uop_fire    = uop_valid_i & uop_ready_o;

    // Address phase comes straight from the stage register, so it is stable
    // for as long as the request waits for its grant.
    assign data_req_o   = stage_vld_q;
    assign data_addr_o  = stage_q.addr;
    assign data_we_o    = stage_q.we;
    assign data_wdata_o = stage_q.wdata;
    assign data_be_o    = stage_vld_q ? 4'b1111 : 4'b0000;

    assign fifo_in = '{we: stage_q.we, rf_reg: stage_q.rf_reg, last: stage_q.last};

    riscv_pushpop_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (gnt_fire),
        .push_data_i (fifo_in),
        .pop_i       (rsp_fire),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Register-file writeback is combinational from rvalid; errored beats,
    // store acknowledgements and x0 never write.
    assign rf_we_o    = rsp_fire & ~fifo_head.we & ~data_err_i & (fifo_head.rf_reg != 5'd0);
    assign rf_waddr_o = rf_we_o ? fifo_head.rf_reg : 5'd0;
    assign rf_wdata_o = rf_we_o ? data_rdata_i : 32'd0;

    assign seq_done = (state_q == PP_DRAIN) & rsp_fire & fifo_head.last;
    assign done_o   = seq_done;
    assign err_o    = seq_done & (sticky_err_q | data_err_i);
    assign busy_o   = (state_q != PP_IDLE);

    always_comb begin
        stage_d      = stage_q;
        stage_vld_d  = stage_vld_q;
        cnt_d        = cnt_q + CNT_W'(gnt_fire) - CNT_W'(rsp_fire);
        sticky_err_d = seq_done ? 1'b0 : (sticky_err_q | (rsp_fire & data_err_i));
        state_d      = state_q;

        if (gnt_fire) begin
            stage_vld_d = 1'b0;
        end
        if (uop_fire) begin
            stage_vld_d    = 1'b1;
            stage_d.addr   = pushpop_addr(sp_i, uop_offset_i);
            stage_d.we     = uop_push_i;
            stage_d.wdata  = uop_wdata_i;
            stage_d.rf_reg = uop_reg_i;
            stage_d.last   = uop_last_i;
        end

        case (state_q)
            PP_IDLE:  if (uop_fire) state_d = PP_ISSUE;
            PP_ISSUE: if (gnt_fire && stage_q.last) state_d = PP_DRAIN;
            PP_DRAIN: if (seq_done) state_d = PP_IDLE;
            default:  state_d = PP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
            stage_vld_q  <= 1'b0;
            cnt_q        <= '0;
            sticky_err_q <= 1'b0;
            state_q      <= PP_IDLE;
        end else begin
            stage_q      <= stage_d;
            stage_vld_q  <= stage_vld_d;
            cnt_q        <= cnt_d;
            sticky_err_q <= sticky_err_d;
            state_q      <= state_d;
        end
    end

endmodule

// File: tb/tb_riscv_pushpop_lsu_seq.sv
module tb_riscv_pushpop_lsu_seq;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uop_valid_i = 1'b0, uop_push_i = 1'b0, uop_last_i = 1'b0;
    logic [4:0]  uop_reg_i = '0;
    logic [31:0] uop_offset_i = '0, uop_wdata_i = '0, sp_i = '0;
    logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
    logic [31:0] data_rdata_i = '0;
    logic        uop_ready_o, data_req_o, data_we_o, rf_we_o, busy_o, done_o, err_o;
    logic [31:0] data_addr_o, data_wdata_o, rf_wdata_o;
    logic [3:0]  data_be_o;
    logic [4:0]  rf_waddr_o;

    always #5 clk = ~clk;

    riscv_pushpop_lsu_seq #(.MAX_OUTSTANDING(MAXO), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .uop_valid_i(uop_valid_i), .uop_ready_o(uop_ready_o), .uop_push_i(uop_push_i),
        .uop_reg_i(uop_reg_i), .uop_offset_i(uop_offset_i), .uop_wdata_i(uop_wdata_i),
        .uop_last_i(uop_last_i), .sp_i(sp_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: ops in flight, in order ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [4:0]  rg;
        logic        last;
    } op_t;

    op_t  mdl_bus[$];   // accepted, not yet granted
    op_t  mdl_rsp[$];   // granted, awaiting response
    bit   mdl_busy = 0, mdl_drain = 0, mdl_sticky = 0;
    op_t  h;

    // observation logs
    int          done_cnt = 0;
    logic        last_err = 1'b0;
    logic [4:0]  rfw_addr[$];
    logic [31:0] rfw_data[$];
    logic [31:0] g_addr[$];
    logic        g_we[$];

    // ---------------- OBI slave knobs ----------------
    int          gnt_pct = 100, rv_pct = 100, err_pct = 0;
    int          sl_pend = 0;
    bit          err_plan[$];
    logic [31:0] rd_plan[$];
    logic        sl_gnt_n = 1'b0, sl_rv_n = 1'b0, sl_err_n = 1'b0;
    logic [31:0] sl_rd_n = '0;

    logic stg, gf, exp_rdy, exp_we, exp_done, exp_err;

    always @(negedge clk) begin
        if (rst_n) begin
            stg     = (mdl_bus.size() != 0);
            gf      = stg && data_gnt_i;
            exp_rdy = (!stg || gf) && ((mdl_rsp.size() + mdl_bus.size()) < MAXO) && !mdl_drain;
            chk("req", data_req_o, stg);
            chk("ready", uop_ready_o, exp_rdy);
            chk("busy", busy_o, mdl_busy);

            exp_we = 0; exp_done = 0; exp_err = 0;
            if (data_rvalid_i && mdl_rsp.size() != 0) begin
                h = mdl_rsp.pop_front();
                exp_we = !h.we && !data_err_i && (h.rg != 5'd0);
                if (h.last) begin
                    exp_done   = 1;
                    exp_err    = mdl_sticky | data_err_i;
                    mdl_sticky = 0;
                    mdl_drain  = 0;
                    mdl_busy   = 0;
                end else begin
                    mdl_sticky = mdl_sticky | data_err_i;
                end
                if (exp_we) begin
                    chk("rf_waddr", rf_waddr_o, h.rg);
                    chk("rf_wdata", rf_wdata_o, data_rdata_i);
                end
            end
            chk("rf_we", rf_we_o, exp_we);
            chk("done", done_o, exp_done);
            chk("err", err_o, exp_err);
            if (rf_we_o) begin rfw_addr.push_back(rf_waddr_o); rfw_data.push_back(rf_wdata_o); end
            if (done_o) begin done_cnt++; last_err = err_o; end

            if (gf) begin
                h = mdl_bus.pop_front();
                chk("gnt_addr", data_addr_o, h.addr);
                chk("gnt_we", data_we_o, h.we);
                chk("gnt_be", data_be_o, 4'hF);
                if (h.we) chk("gnt_wdata", data_wdata_o, h.wdata);
                g_addr.push_back(data_addr_o);
                g_we.push_back(data_we_o);
                mdl_rsp.push_back(h);
                if (h.last) mdl_drain = 1;
            end
        end

        // slave: remember granted beats, answer them later in order
        if (data_req_o && data_gnt_i) sl_pend++;
        if (data_rvalid_i && sl_pend > 0) sl_pend--;
        sl_gnt_n = ($urandom_range(99) < gnt_pct);
        sl_rv_n  = (sl_pend > 0) && ($urandom_range(99) < rv_pct);
        sl_err_n = 1'b0;
        sl_rd_n  = $urandom;
        if (sl_rv_n) begin
            if (err_plan.size() != 0) sl_err_n = err_plan.pop_front();
            else                      sl_err_n = ($urandom_range(99) < err_pct);
            if (rd_plan.size() != 0)  sl_rd_n = rd_plan.pop_front();
        end
    end

    always @(posedge clk) begin
        #1;
        data_gnt_i    = sl_gnt_n;
        data_rvalid_i = sl_rv_n;
        data_err_i    = sl_err_n;
        data_rdata_i  = sl_rd_n;
    end

    // ---------------- sequence description + driver ----------------
    logic        s_push;
    logic [31:0] s_sp;
    int          s_n;
    logic [4:0]  s_reg[8];
    logic [31:0] s_off[8];
    logic [31:0] s_wd[8];

    task automatic load_seq(input logic push, input logic [31:0] sp, input int n);
        s_push = push; s_sp = sp; s_n = n;
        for (int i = 0; i < 8; i++) begin
            s_reg[i] = 5'($urandom_range(31));
            s_off[i] = $urandom;
            s_wd[i]  = $urandom;
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic send_ops(input int from, input int to, input bit gaps);
        op_t o;
        for (int i = from; i < to; i++) begin
            int w = 0;
            if (gaps && $urandom_range(3) == 0) begin
                uop_valid_i = 1'b0;
                @(posedge clk); #1;
            end
            uop_valid_i  = 1'b1;
            uop_push_i   = s_push;
            uop_reg_i    = s_reg[i];
            uop_offset_i = s_off[i];
            uop_wdata_i  = s_wd[i];
            uop_last_i   = (i == s_n - 1);
            sp_i         = s_sp;
            @(negedge clk);
            while (!uop_ready_o && w < 100) begin w++; @(negedge clk); end
            if (!uop_ready_o) begin
                chk("accept_timeout", 32'd0, 32'd1);
                uop_valid_i = 1'b0;
                return;
            end
            @(posedge clk);
            o.addr  = (s_sp + s_off[i]) & 32'hFFFF_FFFC;
            o.we    = s_push;
            o.wdata = s_wd[i];
            o.rg    = s_reg[i];
            o.last  = (i == s_n - 1);
            mdl_bus.push_back(o);
            mdl_busy = 1;
            #1;
        end
        uop_valid_i  = 1'b0;
        uop_offset_i = $urandom;
        uop_wdata_i  = $urandom;
        sp_i         = $urandom;
    endtask

    task automatic wait_done();
        int w = 0;
        while (mdl_busy && w < 400) begin w++; @(negedge clk); end
        chk("done_timeout", {31'd0, mdl_busy}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"}, data_req_o, 0);
        chk({tag, "_addr"}, data_addr_o, 0);
        chk({tag, "_we"}, data_we_o, 0);
        chk({tag, "_be"}, data_be_o, 0);
        chk({tag, "_wdata"}, data_wdata_o, 0);
        chk({tag, "_rf_we"}, rf_we_o, 0);
        chk({tag, "_rf_waddr"}, rf_waddr_o, 0);
        chk({tag, "_rf_wdata"}, rf_wdata_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, c0;
        logic [31:0] cap;

        // ---- reset ----
        repeat (3) @(negedge clk);
        chk_idle_outputs("rst");
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post_rst");
        @(posedge clk); #1;

        // ---- 1: push ra,s0,s1 below sp=0x1000 ----
        gnt_pct = 100; rv_pct = 100;
        load_seq(1'b1, 32'h1000, 3);
        s_reg[0] = 5'd1; s_reg[1] = 5'd8; s_reg[2] = 5'd9;
        s_off[0] = -32'sd12; s_off[1] = -32'sd8; s_off[2] = -32'sd4;
        g_addr.delete(); g_we.delete(); rfw_addr.delete(); d0 = done_cnt;
        send_ops(0, 3, 0);
        wait_done();
        chk("t1_ngnt", g_addr.size(), 3);
        if (g_addr.size() == 3) begin
            chk("t1_a0", g_addr[0], 32'hFF4);
            chk("t1_a1", g_addr[1], 32'hFF8);
            chk("t1_a2", g_addr[2], 32'hFFC);
            chk("t1_we", {g_we[0], g_we[1], g_we[2]}, 3'b111);
        end
        chk("t1_rfw", rfw_addr.size(), 0);
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", last_err, 0);

        // ---- 2: pop ra,s0 with fixed data ----
        load_seq(1'b0, 32'h0000_2000, 2);
        s_reg[0] = 5'd1; s_reg[1] = 5'd8;
        s_off[0] = -32'sd8; s_off[1] = -32'sd4;
        rd_plan.push_back(32'hAAAA_0001); rd_plan.push_back(32'hBBBB_0002);
        rfw_addr.delete(); rfw_data.delete(); d0 = done_cnt;
        send_ops(0, 2, 0);
        wait_done();
        chk("t2_nrfw", rfw_addr.size(), 2);
        if (rfw_addr.size() == 2) begin
            chk("t2_w0a", rfw_addr[0], 5'd1);
            chk("t2_w0d", rfw_data[0], 32'hAAAA_0001);
            chk("t2_w1a", rfw_addr[1], 5'd8);
            chk("t2_w1d", rfw_data[1], 32'hBBBB_0002);
        end
        chk("t2_done", done_cnt - d0, 1);

        // ---- 3: grant withheld for 5 cycles ----
        gnt_pct = 0;
        load_seq(1'b0, $urandom, 3);
        send_ops(0, 1, 0);
        @(negedge clk);
        cap = data_addr_o;
        chk("t3_req0", data_req_o, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_req", data_req_o, 1);
            chk("t3_addr", data_addr_o, cap);
            chk("t3_rdy", uop_ready_o, 0);
        end
        gnt_pct = 100;
        @(posedge clk); #1;
        send_ops(1, 3, 0);
        wait_done();

        // ---- 4: error on 2nd of 3 pop beats, then a clean sequence ----
        rv_pct = 60;
        load_seq(1'b0, $urandom, 3);
        s_reg[0] = 5'd5; s_reg[1] = 5'd6; s_reg[2] = 5'd7;
        err_plan.push_back(1'b0); err_plan.push_back(1'b1); err_plan.push_back(1'b0);
        rfw_addr.delete(); rfw_data.delete();
        send_ops(0, 3, 0);
        wait_done();
        chk("t4_nrfw", rfw_addr.size(), 2);
        if (rfw_addr.size() == 2) begin
            chk("t4_w0a", rfw_addr[0], 5'd5);
            chk("t4_w1a", rfw_addr[1], 5'd7);
        end
        chk("t4_err", last_err, 1);
        load_seq(1'b1, $urandom, 2);
        send_ops(0, 2, 0);
        wait_done();
        chk("t4_err_clr", last_err, 0);

        // ---- 5: gnt and rvalid together, back-to-back ----
        rv_pct = 100;
        load_seq(1'b0, $urandom, 4);
        for (int i = 0; i < 4; i++) s_reg[i] = 5'(10 + i);
        rfw_addr.delete(); d0 = done_cnt;
        send_ops(0, 4, 0);
        wait_done();
        chk("t5_nrfw", rfw_addr.size(), 4);
        chk("t5_done", done_cnt - d0, 1);

        // ---- random sequences ----
        err_pct = 10;
        for (int k = 0; k < 25; k++) begin
            gnt_pct = 30 + $urandom_range(70);
            rv_pct  = 30 + $urandom_range(70);
            load_seq(1'($urandom_range(1)), $urandom, 1 + $urandom_range(5));
            d0 = done_cnt;
            send_ops(0, s_n, 1);
            wait_done();
            chk("rnd_done", done_cnt - d0, 1);
        end
        err_pct = 0;

        // ---- 6: reset with two beats outstanding, late responses ----
        gnt_pct = 100; rv_pct = 0;
        load_seq(1'b0, $urandom, 3);
        for (int i = 0; i < 3; i++) s_reg[i] = 5'(20 + i);
        send_ops(0, 2, 0);
        begin
            int w = 0;
            while (mdl_rsp.size() < 2 && w < 50) begin w++; @(negedge clk); end
            chk("t6_outst", mdl_rsp.size(), 2);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        gnt_pct = 0;
        mdl_bus.delete(); mdl_rsp.delete();
        mdl_busy = 0; mdl_drain = 0; mdl_sticky = 0;
        @(negedge clk);
        chk_idle_outputs("t6_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        rv_pct = 100;
        c0 = rfw_addr.size(); d0 = done_cnt;
        repeat (6) @(negedge clk);
        chk("t6_rfw", rfw_addr.size() - c0, 0);
        chk("t6_done", done_cnt - d0, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_req", data_req_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
